// File: rtl/demux_frame_seq.sv
// Registered 1-to-3 word demultiplexer. Words are steered by s (manual) or by a
// round-robin A->B->C sequencer (auto) that flags and counts completed frames.
module demux_frame_seq #(
  parameter int N      = 4,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      d,
  input  logic              d_valid,
  input  logic [1:0]        s,
  input  logic              auto_en,
  output logic [N-1:0]      a,
  output logic [N-1:0]      b,
  output logic [N-1:0]      c,
  output logic              a_vld,
  output logic              b_vld,
  output logic              c_vld,
  output logic              err,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;

  logic [1:0] st, st_nxt;
  logic [2:0] wr;      // {c, b, a} write strobes for this edge
  logic       drop;
  logic       fin;

  always_comb begin
    wr     = 3'b000;
    drop   = 1'b0;
    fin    = 1'b0;
    st_nxt = st;
    if (!auto_en) begin
      // Manual mode parks the sequencer, abandoning any partial frame.
      st_nxt = CH_A;
      if (d_valid) begin
        case (s)
          2'b00:   wr = 3'b001;
          2'b01:   wr = 3'b010;
          2'b10:   wr = 3'b100;
          default: drop = 1'b1;
        endcase
      end
    end else if (d_valid) begin
      case (st)
        CH_A: begin wr = 3'b001; st_nxt = CH_B; end
        CH_B: begin wr = 3'b010; st_nxt = CH_C; end
        CH_C: begin wr = 3'b100; fin = 1'b1; st_nxt = CH_A; end
        default: st_nxt = CH_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= CH_A;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      a_vld      <= 1'b0;
      b_vld      <= 1'b0;
      c_vld      <= 1'b0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      st         <= st_nxt;
      if (wr[0]) a <= d;
      if (wr[1]) b <= d;
      if (wr[2]) c <= d;
      a_vld      <= wr[0];
      b_vld      <= wr[1];
      c_vld      <= wr[2];
      err        <= drop;
      frame_done <= fin;
      if (fin) frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

endmodule
